sequenciador_entrada: RTL and testbench
=======================================

// Module: sequenciador_entrada
// PURPOSE
//  Controller that plays a programmed list of 7-bit input codes into the code-recognizer FSM, one code per strobe.
//  Clears the recognizer, presents each code with setup/hold around a 1-cycle strobe, then samples the 4-bit recognizer state.
//  Reports the final recognizer state (result) and a done pulse; sits between the panel/host logic and the recognizer.
// PARAMETERS
//  MAX_LEN        8   depth of code memory (codes per run)
//  CODE_W         7   width of one input code (recognizer bits b7..b1)
//  STATE_W        4   width of recognizer state {a,b,c,d}
//  SETTLE_CYCLES  2   cycles strobe stays low after release before state is sampled (>=1)
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        synchronous, active-high
//  load_en    in   1        write load_code into code memory at load_addr
//  load_addr  in   3        code memory index (clog2(MAX_LEN))
//  load_code  in   CODE_W   code to store
//  seq_len    in   4        codes to play this run; sampled on start
//  start      in   1        begin run (IDLE only)
//  busy       out  1        high from accepted start until done cycle inclusive
//  done       out  1        1-cycle pulse: run finished, result valid
//  result     out  STATE_W  recognizer state sampled at end of run; held until next start
//  out_code   out  CODE_W   code driven to recognizer b7..b1
//  out_strobe out  1        to recognizer b8
//  out_reset  out  1        to recognizer reset
//  in_state   in   STATE_W  recognizer state {a,b,c,d}
// BEHAVIOUR
//  Clock clk; reset synchronous active-high. Reset values: busy=0, done=0, result=0000, out_code=0, out_strobe=0,
//   out_reset=1 (for the cycle after reset asserts; recognizer cleared together), FSM=IDLE, index=0, code memory all 0.
//  Reset mid-run: abort, no done pulse, all outputs to reset values next edge.
//  FSM: IDLE -> CLEAR -> PRESENT -> STROBE -> RELEASE(xSETTLE_CYCLES) -> CHECK -> (PRESENT | DONE) -> IDLE.
//   IDLE:    start=1 latches len=min(seq_len,MAX_LEN), index=0, busy=1 -> CLEAR. start while busy ignored.
//   CLEAR:   out_reset=1 one cycle; len==0 -> DONE, else PRESENT.
//   PRESENT: out_code=mem[index], strobe 0 (1 cycle setup).
//   STROBE:  out_strobe=1 exactly one cycle, out_code unchanged.
//   RELEASE: strobe 0, out_code still held (hold); count SETTLE_CYCLES.
//   CHECK:   sample in_state; index==len-1 -> DONE, else index+1 -> PRESENT.
//   DONE:    result<=in_state, done=1 one cycle, busy=1 this cycle, out_code<=0 -> IDLE.
//  Latency: start at edge k -> out_reset k+1, first strobe cycle k+3; each code takes 3+SETTLE_CYCLES cycles.
//  out_code changes only while out_strobe=0; never two strobes in consecutive cycles.
//  load_en while busy ignored (memory stable during run); load and start same IDLE cycle: write occurs, run uses new value.
//  Terminal recognizer states: 1001 (success A), 1010 (success B), 1000 (error).
// CONFIGURATION
//  SEQ_EARLY_STOP_EN defined: CHECK also goes to DONE when in_state is terminal; remaining codes not strobed.
//  Not defined: all len codes always strobed regardless of in_state; result is final state.
// STRUCTURE
//  Package seq_pkg: FSM state enum, terminal-state constants (EST_OK_A=4'b1001, EST_OK_B=4'b1010, EST_ERRO=4'b1000),
//   recognizer code constants (e.g. 7'b1011000, 7'b1101011, 7'b0110010, 7'b0100011), is_terminal() function.
//  One sub-module: seq_code_mem (MAX_LEN x CODE_W, sync write, async read, sync clear on reset).
// TESTING (bench includes a recognizer model; count strobes)
//  codes {1011000,1101011,0110010}, len 3 -> states 0001,0010,1001; result 1001, 3 strobes, done once.
//  codes {0101000,0100011}, len 2 -> states 0100,1010; result 1010.
//  codes {1011000,1011000,1101011}, len 3 -> with SEQ_EARLY_STOP_EN: 2 strobes, result 1000; without: 3 strobes, result 1000.
//  seq_len 0, start -> one out_reset cycle, no strobe, done 2 cycles after start, result 0000.
//  seq_len 12 -> clamped: exactly 8 strobes; start pulsed again while busy -> ignored.
//  reset asserted during RELEASE of code 2 -> next edge busy=0, strobe=0, out_reset=1, no done; new run then passes.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the input sequencer that drives the code recognizer.
// Holds the sequencer FSM encoding, the recognizer terminal states and the known recognizer codes.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PRESENT,
        ST_STROBE,
        ST_RELEASE,
        ST_CHECK,
        ST_DONE
    } seq_state_t;

    // Recognizer state encoding {a,b,c,d}
    localparam logic [3:0] EST_INICIAL = 4'b0000;
    localparam logic [3:0] EST_OK_A    = 4'b1001;
    localparam logic [3:0] EST_OK_B    = 4'b1010;
    localparam logic [3:0] EST_ERRO    = 4'b1000;

    // Codes the recognizer reacts to (b7..b1)
    localparam logic [6:0] COD_PASSO_1 = 7'b1011000;
    localparam logic [6:0] COD_PASSO_2 = 7'b1101011;
    localparam logic [6:0] COD_PASSO_3 = 7'b0110010;
    localparam logic [6:0] COD_ALT_1   = 7'b0101000;
    localparam logic [6:0] COD_ALT_2   = 7'b0100011;

    function automatic logic is_terminal(input logic [3:0] s);
        return (s == EST_OK_A) || (s == EST_OK_B) || (s == EST_ERRO);
    endfunction

endpackage

// File: rtl/seq_code_mem.sv
// Small code memory for the input sequencer: synchronous write, asynchronous read.
// Contents are cleared synchronously while reset is asserted.
module seq_code_mem #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 7,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sequenciador_entrada.sv
// Plays a programmed list of codes into the code recognizer, one strobe per code, and reports its final state.
// Optional SEQ_EARLY_STOP_EN: stop the run as soon as the recognizer reaches a terminal state.
module sequenciador_entrada
    import seq_pkg::*;
#(
    parameter int MAX_LEN       = 8,
    parameter int CODE_W        = 7,
    parameter int STATE_W       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [$clog2(MAX_LEN)-1:0] load_addr,
    input  logic [CODE_W-1:0]          load_code,
    input  logic [3:0]                 seq_len,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [STATE_W-1:0]         result,
    output logic [CODE_W-1:0]          out_code,
    output logic                       out_strobe,
    output logic                       out_reset,
    input  logic [STATE_W-1:0]         in_state
);

    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = 4;
    localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);

    seq_state_t          state;
    seq_state_t          next_state;
    logic [ADDR_W-1:0]   index;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    len_clamped;
    logic [CNT_W-1:0]    settle_cnt;
    logic [CODE_W-1:0]   mem_code;
    logic                rst_flag;
    logic                last_code;
    logic                stop_now;
    logic                mem_wr_en;

    // Memory is frozen for the whole run so the played list cannot change underneath the FSM
    assign mem_wr_en = load_en && (state == ST_IDLE);

    seq_code_mem #(
        .DEPTH (MAX_LEN),
        .WIDTH (CODE_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (mem_wr_en),
        .wr_addr(load_addr),
        .wr_data(load_code),
        .rd_addr(index),
        .rd_data(mem_code)
    );

    assign len_clamped = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;
    assign last_code   = (LEN_W'(index) == (len - LEN_W'(1)));

`ifdef SEQ_EARLY_STOP_EN
    assign stop_now = last_code || is_terminal(in_state[3:0]);
`else
    assign stop_now = last_code;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (len == '0) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_PRESENT;
                end
            end
            ST_PRESENT: next_state = ST_STROBE;
            ST_STROBE:  next_state = ST_RELEASE;
            ST_RELEASE: begin
                if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (stop_now) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_PRESENT;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Result is captured on the way into DONE so it is already valid while done is high;
    // an empty run reports the freshly cleared recognizer, i.e. all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            index      <= '0;
            len        <= '0;
            settle_cnt <= '0;
            result     <= '0;
            rst_flag   <= 1'b1;
        end else begin
            rst_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len   <= len_clamped;
                        index <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (next_state == ST_DONE) begin
                        result <= '0;
                    end
                end
                ST_STROBE: begin
                    settle_cnt <= '0;
                end
                ST_RELEASE: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                end
                ST_CHECK: begin
                    if (next_state == ST_DONE) begin
                        result <= in_state;
                    end else begin
                        index <= index + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Code is shown from PRESENT through CHECK so it brackets the strobe with setup and hold
    always_comb begin
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        out_strobe = (state == ST_STROBE);
        out_reset  = (state == ST_CLEAR) || rst_flag;
        out_code   = '0;
        if ((state == ST_PRESENT) || (state == ST_STROBE) ||
            (state == ST_RELEASE) || (state == ST_CHECK)) begin
            out_code = mem_code;
        end
    end

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Self-checking bench for sequenciador_entrada with a behavioural code-recognizer attached.
// Expected results come from replaying the programmed code list through the recognizer rules.
module tb_sequenciador_entrada;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [2:0] load_addr;
    logic [6:0] load_code;
    logic [3:0] seq_len;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [6:0] out_code;
    logic       out_strobe;
    logic       out_reset;
    logic [3:0] in_state;

    int vectors     = 0;
    int miscompares = 0;
    int strobe_cnt  = 0;
    int done_cnt    = 0;
    int viol_cnt    = 0;

    logic [6:0] mem_model [8];
    logic [3:0] rec_state = 4'b0000;
    logic       prev_strobe = 1'b0;
    logic [6:0] prev_code = 7'd0;

    always #5 clk = ~clk;

    sequenciador_entrada dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_code (load_code),
        .seq_len   (seq_len),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .out_code  (out_code),
        .out_strobe(out_strobe),
        .out_reset (out_reset),
        .in_state  (in_state)
    );

    function automatic logic rec_terminal(input logic [3:0] s);
        return (s == 4'b1001) || (s == 4'b1010) || (s == 4'b1000);
    endfunction

    // Recognizer rules: two accepting paths, anything unexpected is an error; terminals are sticky
    function automatic logic [3:0] rec_step(input logic [3:0] s, input logic [6:0] c);
        if (rec_terminal(s)) return s;
        case (s)
            4'b0000: return (c == 7'b1011000) ? 4'b0001 : (c == 7'b0101000) ? 4'b0100 : 4'b1000;
            4'b0001: return (c == 7'b1101011) ? 4'b0010 : 4'b1000;
            4'b0010: return (c == 7'b0110010) ? 4'b1001 : 4'b1000;
            4'b0100: return (c == 7'b0100011) ? 4'b1010 : 4'b1000;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [6:0] rand_code();
        case ($urandom_range(0, 5))
            0: return 7'b1011000;
            1: return 7'b1101011;
            2: return 7'b0110010;
            3: return 7'b0101000;
            4: return 7'b0100011;
            default: return 7'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        if (out_reset === 1'b1) rec_state <= 4'b0000;
        else if (out_strobe === 1'b1) rec_state <= rec_step(rec_state, out_code);
    end
    assign in_state = rec_state;

    always @(posedge clk) begin
        if (out_strobe === 1'b1) strobe_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Strobes never back to back, and the code must not move while the strobe is high
    always @(negedge clk) begin
        if (out_strobe === 1'b1 && prev_strobe === 1'b1) viol_cnt++;
        if (out_strobe === 1'b1 && out_code !== prev_code) viol_cnt++;
        prev_strobe = out_strobe;
        prev_code   = out_code;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [6:0] code);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = addr;
        load_code = code;
        @(negedge clk);
        load_en = 1'b0;
        mem_model[addr] = code;
    endtask

    task automatic run_seq(input string tag, input logic [3:0] len_in, input bit garbage,
                           input bit restart, input bit same_load, input logic [6:0] sl_code);
        int         n_len;
        int         exp_strobes;
        int         s0;
        int         d0;
        int         cyc;
        bit         seen;
        logic [3:0] st;
        if (same_load) mem_model[0] = sl_code;
        n_len = (len_in > 4'd8) ? 8 : int'(len_in);
        st = 4'b0000;
        exp_strobes = 0;
        for (int i = 0; i < n_len; i++) begin
            st = rec_step(st, mem_model[i]);
            exp_strobes++;
`ifdef SEQ_EARLY_STOP_EN
            if (rec_terminal(st)) break;
`endif
        end
        s0 = strobe_cnt;
        d0 = done_cnt;
        @(negedge clk);
        seq_len = len_in;
        start   = 1'b1;
        if (same_load) begin
            load_en   = 1'b1;
            load_addr = 3'd0;
            load_code = sl_code;
        end
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        checkOutput({tag, "_clear_out_reset"}, 32'(out_reset), 32'd1);
        checkOutput({tag, "_clear_busy"}, 32'(busy), 32'd1);
        cyc  = 1;
        seen = 1'b0;
        while (cyc < 400) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (garbage) begin
                load_en   = 1'b1;
                load_addr = 3'($urandom_range(0, 7));
                load_code = 7'($urandom);
            end
            if (restart && cyc == 4) begin
                start   = 1'b1;
                seq_len = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        load_en = 1'b0;
        start   = 1'b0;
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(2 + exp_strobes * (3 + SETTLE)));
        checkOutput({tag, "_result"}, 32'(result), 32'(st));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        checkOutput({tag, "_strobes"}, 32'(strobe_cnt - s0), 32'(exp_strobes));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_result_held"}, 32'(result), 32'(st));
        checkOutput({tag, "_idle_code"}, 32'(out_code), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int s0;
        int d0;
        reset     = 1'b1;
        load_en   = 1'b0;
        load_addr = 3'd0;
        load_code = 7'd0;
        seq_len   = 4'd0;
        start     = 1'b0;
        for (int i = 0; i < 8; i++) mem_model[i] = 7'd0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_code", 32'(out_code), 32'd0);
        checkOutput("rst_strobe", 32'(out_strobe), 32'd0);
        checkOutput("rst_out_reset", 32'(out_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_out_reset", 32'(out_reset), 32'd0);

        $display("[TB] cleared memory run");
        run_seq("zero_mem", 4'd8, 1'b0, 1'b0, 1'b0, 7'd0);

        $display("[TB] success path A");
        applyStimulus(3'd0, 7'b1011000);
        applyStimulus(3'd1, 7'b1101011);
        applyStimulus(3'd2, 7'b0110010);
        run_seq("path_a", 4'd3, 1'b0, 1'b0, 1'b0, 7'd0);

        $display("[TB] success path B");
        applyStimulus(3'd0, 7'b0101000);
        applyStimulus(3'd1, 7'b0100011);
        run_seq("path_b", 4'd2, 1'b0, 1'b0, 1'b0, 7'd0);

        $display("[TB] error path");
        applyStimulus(3'd0, 7'b1011000);
        applyStimulus(3'd1, 7'b1011000);
        applyStimulus(3'd2, 7'b1101011);
        run_seq("error", 4'd3, 1'b0, 1'b0, 1'b0, 7'd0);

        $display("[TB] empty run");
        run_seq("len0", 4'd0, 1'b0, 1'b0, 1'b0, 7'd0);

        $display("[TB] clamped run with restart attempt and loads while busy");
        for (int i = 0; i < 8; i++) applyStimulus(3'(i), rand_code());
        run_seq("clamp", 4'd12, 1'b1, 1'b1, 1'b0, 7'd0);

        $display("[TB] load and start in the same cycle");
        applyStimulus(3'd0, 7'b0000001);
        applyStimulus(3'd1, 7'b1101011);
        applyStimulus(3'd2, 7'b0110010);
        run_seq("same_load", 4'd3, 1'b0, 1'b0, 1'b1, 7'b1011000);

        $display("[TB] reset during release of the second code");
        s0 = strobe_cnt;
        d0 = done_cnt;
        @(negedge clk);
        seq_len = 4'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("midrst_in_release", 32'(out_strobe), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_strobe", 32'(out_strobe), 32'd0);
        checkOutput("midrst_out_reset", 32'(out_reset), 32'd1);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_code", 32'(out_code), 32'd0);
        checkOutput("midrst_result", 32'(result), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mem_model[i] = 7'd0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("midrst_strobes", 32'(strobe_cnt - s0), 32'd2);
        applyStimulus(3'd0, 7'b1011000);
        applyStimulus(3'd1, 7'b1101011);
        applyStimulus(3'd2, 7'b0110010);
        run_seq("after_rst", 4'd3, 1'b0, 1'b0, 1'b0, 7'd0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 1) == 1) applyStimulus(3'(i), rand_code());
            end
            run_seq($sformatf("rand%0d", r), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), rand_code());
        end

        checkOutput("protocol_violations", 32'(viol_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
